maze_path_checker: RTL and testbench
====================================

Name: maze_path_checker

Overview:
- Sits directly downstream of the 15x15 maze solver.
- Snoops the same serial maze stream (maze/in_valid) that feeds the solver and stores the 225-cell maze internally.
- Consumes the solver's path stream (out_valid/out_x/out_y/maze_not_valid) and checks it is a legal walk from start to end through open cells.
- Reports one pass/fail verdict, an error code and the path length per maze; used for in-system self-check and as a bench scoreboard.

Parameters:
- START_X, 0, x coordinate of the required first path cell
- START_Y, 0, y coordinate of the required first path cell
- END_X, 14, x coordinate of the required last path cell
- END_Y, 14, y coordinate of the required last path cell
- TIMEOUT, 3000, maximum idle cycles in WAIT before the timeout error

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  maze bit valid; 225 consecutive cycles per maze
- maze  input  1  maze cell: 1 = open, 0 = wall; raster order, index = y*15+x, x fastest
- out_valid  input  1  solver path coordinate valid
- out_x  input  4  path cell x
- out_y  input  4  path cell y
- maze_not_valid  input  1  solver flags the maze as unsolvable (single-cycle pulse)
- chk_done  output  1  one-cycle pulse: verdict valid
- chk_pass  output  1  1 = path legal or not-valid flag accepted
- chk_err  output  3  first error: 0 none, 1 bad start, 2 non-adjacent step, 3 wall cell, 4 coordinate >14, 5 bad end, 6 protocol, 7 timeout
- chk_not_valid  output  1  verdict came from maze_not_valid
- path_len  output  8  number of out_valid cycles, saturating at 255

Behaviour:
- Reset: clk and rst_n are the only clock and reset; rst_n is asynchronous, active-low. All outputs 0, state IDLE, maze store cleared, counters 0. Reset mid-operation aborts with no chk_done.
- FSM states: IDLE, LOAD, WAIT, PATH, REPORT.
- IDLE:
  - in_valid=1 stores the first bit at index 0 and enters LOAD.
  - The same cycle clears chk_pass, chk_err, chk_not_valid and path_len. These are otherwise held from the previous verdict.
- LOAD:
  - Each in_valid=1 cycle stores maze at the index counter, then increments it.
  - After index 224 is stored, go to WAIT with the timeout counter at 0.
  - in_valid=0 before 225 bits: chk_err=6, go to REPORT.
- WAIT:
  - out_valid=1: check the cell as the first path cell, path_len=1, go to PATH.
  - maze_not_valid=1 with out_valid=0: chk_not_valid=1, chk_err=0, go to REPORT.
  - in_valid=1: chk_err=6, go to REPORT.
  - Timeout counter increments each cycle; reaching TIMEOUT gives chk_err=7, go to REPORT.
- First-cell check:
  - Coordinate >14: err 4, else
  - (x,y) != (START_X,START_Y): err 1, else
  - stored bit 0: err 3.
- PATH, each out_valid=1 cycle:
  - path_len increments, saturating at 255.
  - Check order: coordinate >14 (err 4), then |dx|+|dy| != 1 versus the previous registered cell (err 2), then stored bit 0 (err 3).
  - Only the first error is latched. The remainder of the stream is consumed without updating chk_err.
- PATH exit:
  - First cycle with out_valid=0: if no error is latched and the last cell != (END_X,END_Y), err 5. Go to REPORT.
  - out_valid and maze_not_valid high together, in any state: err 6. maze_not_valid during PATH: err 6.
- REPORT:
  - chk_done=1 for exactly one cycle; chk_pass = (chk_err==0). Return to IDLE.
  - Latency: chk_done is high in the cycle after the first out_valid=0 sample, or after the maze_not_valid sample.
- A one-cell path is legal only if START equals END.
- The checker does not verify shortest path or revisits.

Test Plan:
- Open 15x15 maze, path (0,0)->(1,0)->...->(14,0)->(14,1)->...->(14,14), 29 cells -> chk_done one cycle after out_valid falls, chk_pass=1, chk_err=0, path_len=29.
- Same maze with a wall at (7,0), path through it -> chk_pass=0, chk_err=3, path_len=29.
- Path with a step (3,0)->(5,0) -> chk_err=2; a later wall hit still reports 2.
- Path starting at (1,0) -> chk_err=1. Path ending at (14,13) -> chk_err=5.
- maze_not_valid pulse 40 cycles after load -> chk_done, chk_pass=1, chk_not_valid=1, path_len=0. No solver response for 3000 cycles -> chk_err=7.
- in_valid dropped after 100 bits -> chk_err=6. Reset asserted mid-PATH -> all outputs 0, no chk_done; the next maze checks normally.

Source files
------------

// File: rtl/maze_path_checker.sv
// maze_path_checker: snoops the serial 15x15 maze stream into a local store,
// then checks that the solver's path stream is a legal walk from START to END
// over open cells. Emits one verdict per maze: pass/fail, first error code and
// path length.
module maze_path_checker #(
    parameter int START_X = 0,
    parameter int START_Y = 0,
    parameter int END_X   = 14,
    parameter int END_Y   = 14,
    parameter int TIMEOUT = 3000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       maze,
    input  logic       out_valid,
    input  logic [3:0] out_x,
    input  logic [3:0] out_y,
    input  logic       maze_not_valid,
    output logic       chk_done,
    output logic       chk_pass,
    output logic [2:0] chk_err,
    output logic       chk_not_valid,
    output logic [7:0] path_len
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_START    = 3'd1;
    localparam logic [2:0] ERR_ADJ      = 3'd2;
    localparam logic [2:0] ERR_WALL     = 3'd3;
    localparam logic [2:0] ERR_RANGE    = 3'd4;
    localparam logic [2:0] ERR_END      = 3'd5;
    localparam logic [2:0] ERR_PROTOCOL = 3'd6;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd7;

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, PATH, REPORT} state_t;

    state_t          state_q, state_nxt;
    logic [224:0]    maze_q;
    logic [7:0]      idx_q;
    logic [TW-1:0]   tmo_q;
    logic [3:0]      prev_x_q, prev_y_q;
    logic [2:0]      err_q;
    logic            pass_q;
    logic            nv_q;
    logic [7:0]      len_q;

    // per-cycle check results for the coordinate currently on out_x/out_y
    logic            cur_oob;
    logic [7:0]      cur_idx;
    logic            cur_open;
    logic            cur_is_start;
    logic [3:0]      dx, dy;
    logic            cur_adj;
    logic            prev_is_end;

    // error detected this cycle (ERR_NONE if none) and the error after latching
    logic [2:0]      err_code;
    logic [2:0]      err_after;
    logic            nv_set;
    logic            accept_cell;

    // Evaluate the incoming path coordinate against the stored maze and the
    // previously accepted cell.
    always_comb begin
        cur_oob      = (out_x > 4'd14) || (out_y > 4'd14);
        cur_idx      = 8'(out_y) * 8'd15 + 8'(out_x);
        cur_open     = maze_q[cur_idx];
        cur_is_start = (out_x == 4'(START_X)) && (out_y == 4'(START_Y));
        dx           = (out_x >= prev_x_q) ? (out_x - prev_x_q) : (prev_x_q - out_x);
        dy           = (out_y >= prev_y_q) ? (out_y - prev_y_q) : (prev_y_q - out_y);
        cur_adj      = ((dx == 4'd1) && (dy == 4'd0)) || ((dx == 4'd0) && (dy == 4'd1));
        prev_is_end  = (prev_x_q == 4'(END_X)) && (prev_y_q == 4'(END_Y));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state and error detection.
    always_comb begin
        state_nxt   = state_q;
        err_code    = ERR_NONE;
        nv_set      = 1'b0;
        accept_cell = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) state_nxt = LOAD;
            end
            LOAD: begin
                if (out_valid && maze_not_valid) begin
                    err_code  = ERR_PROTOCOL;
                    state_nxt = REPORT;
                end else if (!in_valid) begin
                    err_code  = ERR_PROTOCOL;
                    state_nxt = REPORT;
                end else if (idx_q == 8'd224) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (out_valid && maze_not_valid) begin
                    err_code  = ERR_PROTOCOL;
                    state_nxt = REPORT;
                end else if (out_valid) begin
                    accept_cell = 1'b1;
                    state_nxt   = PATH;
                    if (cur_oob)            err_code = ERR_RANGE;
                    else if (!cur_is_start) err_code = ERR_START;
                    else if (!cur_open)     err_code = ERR_WALL;
                end else if (maze_not_valid) begin
                    nv_set    = 1'b1;
                    state_nxt = REPORT;
                end else if (in_valid) begin
                    err_code  = ERR_PROTOCOL;
                    state_nxt = REPORT;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_code  = ERR_TIMEOUT;
                    state_nxt = REPORT;
                end
            end
            PATH: begin
                if (maze_not_valid) begin
                    err_code  = ERR_PROTOCOL;
                    state_nxt = REPORT;
                end else if (out_valid) begin
                    accept_cell = 1'b1;
                    if (cur_oob)        err_code = ERR_RANGE;
                    else if (!cur_adj)  err_code = ERR_ADJ;
                    else if (!cur_open) err_code = ERR_WALL;
                end else begin
                    if (!prev_is_end) err_code = ERR_END;
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // only the first error of a maze is kept
        err_after = (err_q != ERR_NONE) ? err_q : err_code;
    end

    // Maze store, counters and verdict registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            maze_q   <= '0;
            idx_q    <= '0;
            tmo_q    <= '0;
            prev_x_q <= '0;
            prev_y_q <= '0;
            err_q    <= '0;
            pass_q   <= 1'b0;
            nv_q     <= 1'b0;
            len_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        maze_q[0] <= maze;
                        idx_q     <= 8'd1;
                        err_q     <= ERR_NONE;
                        pass_q    <= 1'b0;
                        nv_q      <= 1'b0;
                        len_q     <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        maze_q[idx_q] <= maze;
                        idx_q         <= idx_q + 8'd1;
                    end
                    tmo_q <= '0;
                    err_q <= err_after;
                end
                WAIT: begin
                    tmo_q <= tmo_q + TW'(1);
                    err_q <= err_after;
                    if (nv_set) nv_q <= 1'b1;
                    if (accept_cell) begin
                        len_q    <= 8'd1;
                        prev_x_q <= out_x;
                        prev_y_q <= out_y;
                    end
                end
                PATH: begin
                    err_q <= err_after;
                    if (accept_cell) begin
                        if (len_q != 8'hFF) len_q <= len_q + 8'd1;
                        prev_x_q <= out_x;
                        prev_y_q <= out_y;
                    end
                end
                default: begin
                end
            endcase
            // verdict is fixed on the cycle that enters REPORT so it is
            // already valid while chk_done is high
            if ((state_nxt == REPORT) && (state_q != REPORT)) begin
                pass_q <= (err_after == ERR_NONE);
            end
        end
    end

    // Output decode.
    always_comb begin
        chk_done      = (state_q == REPORT);
        chk_pass      = pass_q;
        chk_err       = err_q;
        chk_not_valid = nv_q;
        path_len      = len_q;
    end

endmodule

// File: tb/tb_maze_path_checker.sv
// Self-checking bench for maze_path_checker: each scenario pushes its expected
// verdict and completion cycle into a scoreboard and compares on chk_done.
module tb_maze_path_checker;

    localparam int TMO = 3000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       maze = 1'b0;
    logic       out_valid = 1'b0;
    logic [3:0] out_x = '0;
    logic [3:0] out_y = '0;
    logic       maze_not_valid = 1'b0;
    logic       chk_done;
    logic       chk_pass;
    logic [2:0] chk_err;
    logic       chk_not_valid;
    logic [7:0] path_len;

    typedef struct {
        logic [12:0] v;     // {pass, err[2:0], not_valid, len[7:0]}
        int          cyc;   // cycle at which chk_done must be observed
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  path_q[$];  // {x, y}
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          drop_cyc = 0;
    bit [224:0]  open_maze;

    maze_path_checker #(
        .START_X(0),
        .START_Y(0),
        .END_X(14),
        .END_Y(14),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .maze(maze),
        .out_valid(out_valid),
        .out_x(out_x),
        .out_y(out_y),
        .maze_not_valid(maze_not_valid),
        .chk_done(chk_done),
        .chk_pass(chk_pass),
        .chk_err(chk_err),
        .chk_not_valid(chk_not_valid),
        .path_len(path_len)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [12:0] verdict();
        return {chk_pass, chk_err, chk_not_valid, path_len};
    endfunction

    function automatic string fmt(input logic [12:0] v);
        return $sformatf("pass=%0b err=%0d nv=%0b len=%0d", v[12], v[11:9], v[8], v[7:0]);
    endfunction

    task automatic drive_maze(input bit [224:0] m, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            maze = m[i];
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        maze = 1'b0;
        drop_cyc = cyc;
    endtask

    task automatic drive_path(input int gap);
        repeat (gap) @(posedge clk);
        for (int i = 0; i < path_q.size(); i++) begin
            @(posedge clk); #1;
            out_valid = 1'b1;
            out_x = path_q[i][7:4];
            out_y = path_q[i][3:0];
        end
        @(posedge clk); #1;
        out_valid = 1'b0;
        out_x = '0;
        out_y = '0;
        drop_cyc = cyc;
    endtask

    task automatic build_l_path();
        path_q.delete();
        for (int x = 0; x < 15; x++) path_q.push_back({4'(x), 4'd0});
        for (int y = 1; y < 15; y++) path_q.push_back({4'd14, 4'(y)});
    endtask

    task automatic wait_done(input int budget, output logic seen, output int at);
        seen = 1'b0;
        at = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (chk_done === 1'b1) begin
                seen = 1'b1;
                at = cyc;
            end
        end
    endtask

    task automatic test_reset();
        logic [12:0] got;
        @(negedge clk);
        got = {chk_done, chk_pass, chk_err, chk_not_valid, path_len};
        n_checks++;
        if (got !== 13'd0) $display("FAIL reset_outputs: got %b expected all zero", got);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        got = {chk_done, chk_pass, chk_err, chk_not_valid, path_len};
        n_checks++;
        if (got !== 13'd0) $display("FAIL reset_idle: got %b expected all zero", got);
        else n_pass++;
    endtask

    task automatic test_good_path();
        exp_t e; logic seen; int at; logic [12:0] got;
        build_l_path();
        drive_maze(open_maze, 225);
        drive_path(2);
        sb.push_back('{v: {1'b1, 3'd0, 1'b0, 8'd29}, cyc: drop_cyc + 1});
        wait_done(50, seen, at);
        e = sb.pop_front();
        got = seen ? verdict() : 13'bx;
        n_checks++;
        if (got !== e.v) $display("FAIL good_verdict: got %s expected %s", fmt(got), fmt(e.v));
        else n_pass++;
        n_checks++;
        if (at != e.cyc) $display("FAIL good_latency: done at cycle %0d expected %0d", at, e.cyc);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (chk_done !== 1'b0) $display("FAIL good_done_width: chk_done=%b expected 0 on second cycle", chk_done);
        else n_pass++;
    endtask

    task automatic test_wall();
        exp_t e; logic seen; int at; logic [12:0] got; bit [224:0] m;
        m = open_maze;
        m[7] = 1'b0;
        build_l_path();
        drive_maze(m, 225);
        drive_path(3);
        sb.push_back('{v: {1'b0, 3'd3, 1'b0, 8'd29}, cyc: drop_cyc + 1});
        wait_done(50, seen, at);
        e = sb.pop_front();
        got = seen ? verdict() : 13'bx;
        n_checks++;
        if (got !== e.v) $display("FAIL wall_verdict: got %s expected %s", fmt(got), fmt(e.v));
        else n_pass++;
        n_checks++;
        if (at != e.cyc) $display("FAIL wall_latency: done at cycle %0d expected %0d", at, e.cyc);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t e; logic seen; int at; logic [12:0] got;
        // previous verdict (wall) must be cleared when a new maze starts
        drive_maze(open_maze, 225);
        n_checks++;
        if ({chk_err, path_len} !== 11'd0)
            $display("FAIL b2b_clear: got err=%0d len=%0d expected err=0 len=0", chk_err, path_len);
        else n_pass++;
        build_l_path();
        drive_path(1);
        sb.push_back('{v: {1'b1, 3'd0, 1'b0, 8'd29}, cyc: drop_cyc + 1});
        wait_done(50, seen, at);
        e = sb.pop_front();
        got = seen ? verdict() : 13'bx;
        n_checks++;
        if (got !== e.v) $display("FAIL b2b_first_verdict: got %s expected %s", fmt(got), fmt(e.v));
        else n_pass++;
        // one-cell path at START only: END differs, so the end check fires
        path_q.delete();
        path_q.push_back(8'h00);
        drive_maze(open_maze, 225);
        drive_path(0);
        sb.push_back('{v: {1'b0, 3'd5, 1'b0, 8'd1}, cyc: drop_cyc + 1});
        wait_done(50, seen, at);
        e = sb.pop_front();
        got = seen ? verdict() : 13'bx;
        n_checks++;
        if (got !== e.v) $display("FAIL b2b_one_cell_verdict: got %s expected %s", fmt(got), fmt(e.v));
        else n_pass++;
        n_checks++;
        if (at != e.cyc) $display("FAIL b2b_one_cell_latency: done at cycle %0d expected %0d", at, e.cyc);
        else n_pass++;
    endtask

    task automatic test_step();
        exp_t e; logic seen; int at; logic [12:0] got; bit [224:0] m;
        m = open_maze;
        m[5 * 15 + 14] = 1'b0;   // later wall at (14,5) must not override
        build_l_path();
        path_q.delete(4);        // (3,0) -> (5,0)
        drive_maze(m, 225);
        drive_path(2);
        sb.push_back('{v: {1'b0, 3'd2, 1'b0, 8'd28}, cyc: drop_cyc + 1});
        wait_done(50, seen, at);
        e = sb.pop_front();
        got = seen ? verdict() : 13'bx;
        n_checks++;
        if (got !== e.v) $display("FAIL step_verdict: got %s expected %s", fmt(got), fmt(e.v));
        else n_pass++;
        n_checks++;
        if (at != e.cyc) $display("FAIL step_latency: done at cycle %0d expected %0d", at, e.cyc);
        else n_pass++;
    endtask

    task automatic test_coord_range();
        exp_t e; logic seen; int at; logic [12:0] got;
        path_q.delete();
        path_q.push_back(8'h00);
        path_q.push_back(8'h10);
        path_q.push_back(8'hF0);   // x = 15
        path_q.push_back(8'h20);
        drive_maze(open_maze, 225);
        drive_path(2);
        sb.push_back('{v: {1'b0, 3'd4, 1'b0, 8'd4}, cyc: drop_cyc + 1});
        wait_done(50, seen, at);
        e = sb.pop_front();
        got = seen ? verdict() : 13'bx;
        n_checks++;
        if (got !== e.v) $display("FAIL coord_verdict: got %s expected %s", fmt(got), fmt(e.v));
        else n_pass++;
    endtask

    task automatic test_bad_start();
        exp_t e; logic seen; int at; logic [12:0] got;
        build_l_path();
        void'(path_q.pop_front());  // start at (1,0)
        drive_maze(open_maze, 225);
        drive_path(2);
        sb.push_back('{v: {1'b0, 3'd1, 1'b0, 8'd28}, cyc: drop_cyc + 1});
        wait_done(50, seen, at);
        e = sb.pop_front();
        got = seen ? verdict() : 13'bx;
        n_checks++;
        if (got !== e.v) $display("FAIL start_verdict: got %s expected %s", fmt(got), fmt(e.v));
        else n_pass++;
    endtask

    task automatic test_bad_end();
        exp_t e; logic seen; int at; logic [12:0] got;
        build_l_path();
        void'(path_q.pop_back());   // end at (14,13)
        drive_maze(open_maze, 225);
        drive_path(2);
        sb.push_back('{v: {1'b0, 3'd5, 1'b0, 8'd28}, cyc: drop_cyc + 1});
        wait_done(50, seen, at);
        e = sb.pop_front();
        got = seen ? verdict() : 13'bx;
        n_checks++;
        if (got !== e.v) $display("FAIL end_verdict: got %s expected %s", fmt(got), fmt(e.v));
        else n_pass++;
        n_checks++;
        if (at != e.cyc) $display("FAIL end_latency: done at cycle %0d expected %0d", at, e.cyc);
        else n_pass++;
    endtask

    task automatic test_saturate();
        exp_t e; logic seen; int at; logic [12:0] got;
        path_q.delete();
        for (int i = 0; i < 300; i++) path_q.push_back((i % 2 == 0) ? 8'h00 : 8'h10);
        drive_maze(open_maze, 225);
        drive_path(2);
        sb.push_back('{v: {1'b0, 3'd5, 1'b0, 8'd255}, cyc: drop_cyc + 1});
        wait_done(50, seen, at);
        e = sb.pop_front();
        got = seen ? verdict() : 13'bx;
        n_checks++;
        if (got !== e.v) $display("FAIL saturate_verdict: got %s expected %s", fmt(got), fmt(e.v));
        else n_pass++;
    endtask

    task automatic test_not_valid();
        exp_t e; logic seen; int at; logic [12:0] got;
        drive_maze(open_maze, 225);
        repeat (39) @(posedge clk);
        @(posedge clk); #1;
        maze_not_valid = 1'b1;
        drop_cyc = cyc;
        sb.push_back('{v: {1'b1, 3'd0, 1'b1, 8'd0}, cyc: drop_cyc + 1});
        @(posedge clk); #1;
        maze_not_valid = 1'b0;
        wait_done(50, seen, at);
        e = sb.pop_front();
        got = seen ? verdict() : 13'bx;
        n_checks++;
        if (got !== e.v) $display("FAIL notvalid_verdict: got %s expected %s", fmt(got), fmt(e.v));
        else n_pass++;
        n_checks++;
        if (at != e.cyc) $display("FAIL notvalid_latency: done at cycle %0d expected %0d", at, e.cyc);
        else n_pass++;
    endtask

    task automatic test_timeout();
        exp_t e; logic seen; int at; logic [12:0] got;
        drive_maze(open_maze, 225);
        sb.push_back('{v: {1'b0, 3'd7, 1'b0, 8'd0}, cyc: drop_cyc + TMO});
        wait_done(TMO + 200, seen, at);
        e = sb.pop_front();
        got = seen ? verdict() : 13'bx;
        n_checks++;
        if (got !== e.v) $display("FAIL timeout_verdict: got %s expected %s", fmt(got), fmt(e.v));
        else n_pass++;
        n_checks++;
        if (at < e.cyc - 2 || at > e.cyc + 2)
            $display("FAIL timeout_latency: done at cycle %0d expected %0d +/-2", at, e.cyc);
        else n_pass++;
    endtask

    task automatic test_short_load();
        exp_t e; logic seen; int at; logic [12:0] got;
        drive_maze(open_maze, 100);
        sb.push_back('{v: {1'b0, 3'd6, 1'b0, 8'd0}, cyc: drop_cyc + 1});
        wait_done(50, seen, at);
        e = sb.pop_front();
        got = seen ? verdict() : 13'bx;
        n_checks++;
        if (got !== e.v) $display("FAIL shortload_verdict: got %s expected %s", fmt(got), fmt(e.v));
        else n_pass++;
        n_checks++;
        if (at != e.cyc) $display("FAIL shortload_latency: done at cycle %0d expected %0d", at, e.cyc);
        else n_pass++;
    endtask

    task automatic test_reset_mid_path();
        logic [12:0] got; int dones;
        build_l_path();
        drive_maze(open_maze, 225);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            out_valid = 1'b1;
            out_x = path_q[i][7:4];
            out_y = path_q[i][3:0];
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        out_valid = 1'b0;
        @(negedge clk);
        got = {chk_done, chk_pass, chk_err, chk_not_valid, path_len};
        n_checks++;
        if (got !== 13'd0) $display("FAIL midreset_outputs: got %b expected all zero", got);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (chk_done !== 1'b0) dones++;
        end
        n_checks++;
        if (dones != 0) $display("FAIL midreset_no_done: saw %0d chk_done cycles expected 0", dones);
        else n_pass++;
    endtask

    task automatic test_after_reset();
        exp_t e; logic seen; int at; logic [12:0] got;
        build_l_path();
        drive_maze(open_maze, 225);
        drive_path(2);
        sb.push_back('{v: {1'b1, 3'd0, 1'b0, 8'd29}, cyc: drop_cyc + 1});
        wait_done(50, seen, at);
        e = sb.pop_front();
        got = seen ? verdict() : 13'bx;
        n_checks++;
        if (got !== e.v) $display("FAIL after_reset_verdict: got %s expected %s", fmt(got), fmt(e.v));
        else n_pass++;
        n_checks++;
        if (at != e.cyc) $display("FAIL after_reset_latency: done at cycle %0d expected %0d", at, e.cyc);
        else n_pass++;
    endtask

    initial begin
        open_maze = '1;
        repeat (3) @(posedge clk);
        test_reset();
        test_good_path();
        test_wall();
        test_back_to_back();
        test_step();
        test_coord_range();
        test_bad_start();
        test_bad_end();
        test_saturate();
        test_not_valid();
        test_timeout();
        test_short_load();
        test_reset_mid_path();
        test_after_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
